big_core_lsu: RTL and testbench
===============================

Name: big_core_lsu

Overview:
- Load/store unit directly downstream of the big_core execute stage. Consumes the core's data-memory request (address, store data, size, sign-extend, rd/wr) and converts it into a byte-lane-aligned request to data memory over a valid/ready handshake.
- Returns the shifted, sign- or zero-extended load data to write-back.
- Adds a response timeout so a hung memory cannot hang the core.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles spent in WAIT_RSP before a forced error response; legal range 1..65535.
- TIMEOUT_DATA, 32'hDEAD_BEEF, value returned on CoreRspData when a read times out.

Ports:
- Clk  in  1  core clock
- Rst  in  1  synchronous active-high reset
- CoreReqValid  in  1  request valid from core
- CoreReqReady  out  1  LSU accepts request
- CoreAddress  in  32  byte address
- CoreWrData  in  32  store data, right-justified
- CoreSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- CoreSignExt  in  1  sign-extend load result
- CoreWrEn  in  1  store
- CoreRdEn  in  1  load
- CoreRspValid  out  1  one-cycle response pulse
- CoreRspData  out  32  aligned/extended load data; 0 for stores
- MemReqValid  out  1  memory request valid
- MemReqReady  in  1  memory accepts request
- MemAddress  out  32  word address, {CoreAddress[31:2],2'b00}
- MemWrData  out  32  lane-replicated store data
- MemByteEn  out  4  active byte lanes
- MemWrEn  out  1  write request
- MemRspValid  in  1  read data valid
- MemRspData  in  32  raw word read data
- ErrTimeout  out  1  one-cycle pulse with timed-out response

Behaviour:
- Clock and reset: single clock Clk. Rst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0 except CoreReqReady=1 (it is combinational, asserted in IDLE). Timeout counter is 0.
- Accept: CoreReqReady = (state==IDLE). A request is accepted when CoreReqValid && CoreReqReady && (CoreRdEn || CoreWrEn). Address, data, size, sign and op are latched on acceptance. CoreRdEn and CoreWrEn both high is treated as a store.
- Request accepted with neither CoreRdEn nor CoreWrEn: ignored, no response.
- FSM:
  - IDLE -> REQ on accept.
  - REQ: MemReqValid=1, with address, data, byte-enable and write-enable held stable until MemReqReady.
    - Store: REQ -> DONE on MemReqReady.
    - Load: REQ -> WAIT_RSP on MemReqReady.
  - WAIT_RSP:
    - On MemRspValid, latch the extracted data and go to DONE.
    - Counter increments each cycle. At count==MEM_TIMEOUT with no MemRspValid, go to DONE with data=TIMEOUT_DATA and ErrTimeout=1.
    - MemRspValid on the same cycle the count hits MEM_TIMEOUT wins: normal response, no error.
  - DONE: CoreRspValid=1 for exactly one cycle, then IDLE. The counter clears on entering IDLE.
- Latency: with zero-wait memory (MemReqReady=1 in REQ, MemRspValid the cycle after acceptance), a load response arrives 3 cycles after core acceptance and a store response 2 cycles after.
- Byte enables:
  - byte: 4'b0001<<a[1:0]
  - half: 4'b0011<<{a[1],1'b0}
  - word: 4'b1111
- Store data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Load extraction:
  - shifted = MemRspData >> (8*a[1:0]) for byte, >> (16*a[1]) for half.
  - Mask to the size, then sign-extend from bit 7 or 15 if CoreSignExt, otherwise zero-extend. Word results are unmodified.
- Misalignment (without the optional feature): half uses a[1] only; word ignores a[1:0].
- A MemRspValid that is not in WAIT_RSP (late, after timeout) is dropped silently.
- Rst mid-transaction: the FSM returns to IDLE on the next edge; no CoreRspValid is produced for the aborted request; MemReqValid drops.

Optional Feature:
- Macro: BIG_CORE_LSU_MISALIGN_CHK_EN.
- When defined:
  - Adds output ErrMisalign (1 bit, reset 0).
  - An accepted half with a[0]=1, or word with a[1:0]!=0, skips REQ and goes IDLE -> DONE, with no memory access.
  - Gives CoreRspValid=1, CoreRspData=0 and ErrMisalign=1 for that single cycle.
- When undefined: no port; low address bits are handled as described under Misalignment in Behaviour.

Test Plan:
- Store byte: addr 0x1003, data 0x000000A5 -> MemByteEn 4'b1000, MemWrData 0xA5A5A5A5, MemAddress 0x1000, CoreRspValid 2 cycles after accept with data 0.
- Load half signed: addr 0x2002, MemRspData 0x8001_1234, CoreSignExt=1 -> CoreRspData 0xFFFF8001. Repeat with CoreSignExt=0 -> 0x00008001.
- Backpressure: MemReqReady low for 5 cycles -> MemReqValid and all Mem* fields stable for 5 cycles, CoreReqReady=0 throughout, single response afterwards.
- Timeout: MEM_TIMEOUT=4, load, MemRspValid never asserted -> CoreRspData 0xDEADBEEF and ErrTimeout pulse. A late MemRspValid afterwards produces no response.
- Reset while in WAIT_RSP -> IDLE next cycle, no CoreRspValid. A new word load to 0x3000 with MemRspData 0x12345678 -> CoreRspData 0x12345678.
- (BIG_CORE_LSU_MISALIGN_CHK_EN) word load at 0x4002 -> MemReqValid never asserts, ErrMisalign=1 and CoreRspValid=1 one cycle after accept.

Source files
------------

// File: rtl/big_core_lsu.sv
// Load/store unit: aligns core requests to memory byte lanes and extracts/extends load data.
// Optional BIG_CORE_LSU_MISALIGN_CHK_EN rejects misaligned half/word accesses without touching memory.
module big_core_lsu #(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        CoreReqValid,
  output logic        CoreReqReady,
  input  logic [31:0] CoreAddress,
  input  logic [31:0] CoreWrData,
  input  logic [1:0]  CoreSize,
  input  logic        CoreSignExt,
  input  logic        CoreWrEn,
  input  logic        CoreRdEn,
  output logic        CoreRspValid,
  output logic [31:0] CoreRspData,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWrData,
  output logic [3:0]  MemByteEn,
  output logic        MemWrEn,
  input  logic        MemRspValid,
  input  logic [31:0] MemRspData,
  output logic        ErrTimeout
`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
  ,
  output logic        ErrMisalign
`endif
);

  // state    | meaning
  // IDLE     | ready for a core request
  // REQ      | memory request presented, waiting for MemReqReady
  // WAIT_RSP | load issued, waiting for read data or timeout
  // DONE     | one-cycle response to the core
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} lsuState_t;

  localparam logic [15:0] TMR_LOAD = 16'(MEM_TIMEOUT - 1);

  lsuState_t   state, nextState;
  logic [31:0] addrQ, wrDataQ, rspDataQ, loadData;
  logic [1:0]  sizeQ;
  logic        signExtQ, wrEnQ, timeoutQ;
  logic [15:0] tmrCnt;
  logic        accept, tmrDone, misaligned;
  logic [31:0] shifted;
  logic [3:0]  byteEn;
  logic [31:0] laneData;

  assign accept  = CoreReqValid && (state == IDLE) && (CoreRdEn || CoreWrEn);
  assign tmrDone = (tmrCnt == 16'd0);

`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
  logic misalignQ;
  assign misaligned = ((CoreSize == 2'b01) && CoreAddress[0]) ||
                      (CoreSize[1] && (CoreAddress[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (accept) nextState = misaligned ? DONE : REQ;
      REQ:      if (MemReqReady) nextState = wrEnQ ? DONE : WAIT_RSP;
      WAIT_RSP: if (MemRspValid || tmrDone) nextState = DONE;
      DONE:     nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Response timer counts down from MEM_TIMEOUT-1; terminal count in WAIT_RSP forces the error path.
  always_ff @(posedge Clk) begin
    if (Rst)                                   tmrCnt <= 16'd0;
    else if (state == REQ && MemReqReady)      tmrCnt <= TMR_LOAD;
    else if (state == WAIT_RSP && !tmrDone)    tmrCnt <= tmrCnt - 16'd1;
    else if (state == DONE)                    tmrCnt <= 16'd0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      addrQ    <= '0;
      wrDataQ  <= '0;
      sizeQ    <= '0;
      signExtQ <= 1'b0;
      wrEnQ    <= 1'b0;
      rspDataQ <= '0;
      timeoutQ <= 1'b0;
`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
      misalignQ <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addrQ    <= CoreAddress;
        wrDataQ  <= CoreWrData;
        sizeQ    <= CoreSize;
        signExtQ <= CoreSignExt;
        wrEnQ    <= CoreWrEn;
        rspDataQ <= '0;
        timeoutQ <= 1'b0;
`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
        misalignQ <= misaligned;
`endif
      end
      if (state == WAIT_RSP) begin
        if (MemRspValid) begin
          rspDataQ <= loadData;
        end else if (tmrDone) begin
          rspDataQ <= TIMEOUT_DATA;
          timeoutQ <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    shifted  = MemRspData;
    loadData = MemRspData;
    case (sizeQ)
      2'b00: begin
        shifted  = MemRspData >> {addrQ[1:0], 3'b000};
        loadData = {{24{signExtQ & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        shifted  = MemRspData >> {addrQ[1], 4'b0000};
        loadData = {{16{signExtQ & shifted[15]}}, shifted[15:0]};
      end
      default: loadData = MemRspData;
    endcase
  end

  always_comb begin
    case (sizeQ)
      2'b00: begin
        byteEn   = 4'b0001 << addrQ[1:0];
        laneData = {4{wrDataQ[7:0]}};
      end
      2'b01: begin
        byteEn   = addrQ[1] ? 4'b1100 : 4'b0011;
        laneData = {2{wrDataQ[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = wrDataQ;
      end
    endcase
  end

  always_comb begin
    CoreReqReady = (state == IDLE);
    MemReqValid  = 1'b0;
    MemAddress   = '0;
    MemWrData    = '0;
    MemByteEn    = '0;
    MemWrEn      = 1'b0;
    CoreRspValid = 1'b0;
    CoreRspData  = '0;
    ErrTimeout   = 1'b0;
`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
    ErrMisalign  = 1'b0;
`endif
    if (state == REQ) begin
      MemReqValid = 1'b1;
      MemAddress  = {addrQ[31:2], 2'b00};
      MemWrData   = laneData;
      MemByteEn   = byteEn;
      MemWrEn     = wrEnQ;
    end
    if (state == DONE) begin
      CoreRspValid = 1'b1;
      CoreRspData  = rspDataQ;
      ErrTimeout   = timeoutQ;
`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
      ErrMisalign  = misalignQ;
`endif
    end
  end

endmodule

// File: tb/tb_big_core_lsu.sv
// Directed plus randomized bench for big_core_lsu against an arithmetic reference model.
module tb_big_core_lsu;
  localparam int MT = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        CoreReqValid = 1'b0, CoreReqReady;
  logic [31:0] CoreAddress = '0, CoreWrData = '0;
  logic [1:0]  CoreSize = '0;
  logic        CoreSignExt = 1'b0, CoreWrEn = 1'b0, CoreRdEn = 1'b0;
  logic        CoreRspValid;
  logic [31:0] CoreRspData;
  logic        MemReqValid, MemReqReady = 1'b0;
  logic [31:0] MemAddress, MemWrData;
  logic [3:0]  MemByteEn;
  logic        MemWrEn, MemRspValid = 1'b0;
  logic [31:0] MemRspData = '0;
  logic        ErrTimeout;
  logic        ErrMisalign;

  int nErr = 0;
  int nChecks = 0;

  big_core_lsu #(.MEM_TIMEOUT(MT), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .Clk(Clk), .Rst(Rst),
    .CoreReqValid(CoreReqValid), .CoreReqReady(CoreReqReady),
    .CoreAddress(CoreAddress), .CoreWrData(CoreWrData), .CoreSize(CoreSize),
    .CoreSignExt(CoreSignExt), .CoreWrEn(CoreWrEn), .CoreRdEn(CoreRdEn),
    .CoreRspValid(CoreRspValid), .CoreRspData(CoreRspData),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
    .MemAddress(MemAddress), .MemWrData(MemWrData), .MemByteEn(MemByteEn),
    .MemWrEn(MemWrEn), .MemRspValid(MemRspValid), .MemRspData(MemRspData),
    .ErrTimeout(ErrTimeout)
`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
    , .ErrMisalign(ErrMisalign)
`endif
  );

`ifndef BIG_CORE_LSU_MISALIGN_CHK_EN
  assign ErrMisalign = 1'b0;
`endif

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expLoad(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic sx);
    longint unsigned v;
    longint unsigned lane;
    v = 64'(w);
    if (sz == 2'd0) begin
      lane = 64'(a % 4);
      v = (64'(w) / (64'd1 << (8 * lane))) % 256;
      if (sx && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      lane = 64'((a / 2) % 2);
      v = (64'(w) / (64'd1 << (16 * lane))) % 65536;
      if (sx && v >= 32768) v = v + 64'hFFFF_0000;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] expBe(logic [31:0] a, logic [1:0] sz);
    int first, n;
    if (sz == 2'd0)      begin first = int'(a % 4);           n = 1; end
    else if (sz == 2'd1) begin first = 2 * int'((a / 2) % 2); n = 2; end
    else                 begin first = 0;                     n = 4; end
    return 4'(((1 << n) - 1) << first);
  endfunction

  function automatic logic [31:0] expWd(logic [31:0] d, logic [1:0] sz);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // rspDelay: cycles after the request handshake that read data appears (0 = never)
  task automatic doTxn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mword, input logic [1:0] size, input logic sext,
                       input logic wr, input logic rd, input int stall, input int rspDelay);
    int hs = -1, stallLeft = stall, rspCnt = 0, rspCyc = -1, reqCyc = 0;
    int toCnt = 0, misCnt = 0, window;
    logic [31:0] gotData = '0;
    bit acc = wr || rd;
    bit mis = 1'b0;
    int expReq, expRsp, expCyc, expTo, expMis;
    logic [31:0] expData;
`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
    mis = acc && ((size == 2'd1 && addr % 2 == 1) || (size >= 2'd2 && addr % 4 != 0));
`endif
    expReq = 0; expRsp = 0; expCyc = -1; expTo = 0; expMis = 0; expData = '0;
    if (acc && mis) begin
      expRsp = 1; expCyc = 1; expMis = 1;
    end else if (acc && wr) begin
      expReq = stall + 1; expRsp = 1; expCyc = stall + 2;
    end else if (acc) begin
      expReq = stall + 1; expRsp = 1;
      if (rspDelay >= 1 && rspDelay <= MT) begin
        expCyc = stall + 1 + rspDelay + 1; expData = expLoad(mword, addr, size, sext);
      end else begin
        expCyc = stall + 1 + MT + 1; expData = 32'hDEAD_BEEF; expTo = 1;
      end
    end
    window = stall + MT + 12;

    @(negedge Clk);
    check({tag, "_ready"}, 32'(CoreReqReady), 32'd1);
    CoreReqValid = 1'b1; CoreAddress = addr; CoreWrData = wdata; CoreSize = size;
    CoreSignExt = sext; CoreWrEn = wr; CoreRdEn = rd;
    for (int cyc = 1; cyc <= window; cyc++) begin
      @(negedge Clk);
      CoreReqValid = 1'b0; MemReqReady = 1'b0; MemRspValid = 1'b0; MemRspData = $urandom;
      if (MemReqValid) begin
        reqCyc++;
        check({tag, "_busy"}, 32'(CoreReqReady), 32'd0);
        check({tag, "_maddr"}, MemAddress, addr & 32'hFFFF_FFFC);
        check({tag, "_mbe"}, 32'(MemByteEn), 32'(expBe(addr, size)));
        check({tag, "_mwe"}, 32'(MemWrEn), 32'(wr));
        if (wr) check({tag, "_mwd"}, MemWrData, expWd(wdata, size));
        if (stallLeft > 0) stallLeft--;
        else begin MemReqReady = 1'b1; hs = cyc; end
      end
      if (hs >= 0 && rspDelay > 0 && cyc == hs + rspDelay) begin
        MemRspValid = 1'b1; MemRspData = mword;
      end
      if (CoreRspValid) begin
        rspCnt++; rspCyc = cyc; gotData = CoreRspData;
      end
      if (ErrTimeout) toCnt++;
      if (ErrMisalign) misCnt++;
    end
    check({tag, "_reqcycles"}, 32'(reqCyc), 32'(expReq));
    check({tag, "_rspcount"}, 32'(rspCnt), 32'(expRsp));
    check({tag, "_rspcycle"}, 32'(rspCyc), 32'(expCyc));
    check({tag, "_rspdata"}, gotData, expData);
    check({tag, "_timeout"}, 32'(toCnt), 32'(expTo));
    check({tag, "_misalign"}, 32'(misCnt), 32'(expMis));
  endtask

  initial begin
    int rspSeen;
    logic [1:0] rsz;
    logic rwr, rrd;
    int rdel;

    repeat (2) @(negedge Clk);
    check("rst_ready", 32'(CoreReqReady), 32'd1);
    check("rst_mreqv", 32'(MemReqValid), 32'd0);
    check("rst_rspv", 32'(CoreRspValid), 32'd0);
    check("rst_rspd", CoreRspData, 32'd0);
    check("rst_to", 32'(ErrTimeout), 32'd0);
    check("rst_maddr", MemAddress, 32'd0);
    check("rst_mbe", 32'(MemByteEn), 32'd0);
    Rst = 1'b0;

    doTxn("st_byte", 32'h1003, 32'h0000_00A5, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 0, 0);
    doTxn("ld_half_s", 32'h2002, 32'h0, 32'h8001_1234, 2'd1, 1'b1, 1'b0, 1'b1, 0, 1);
    doTxn("ld_half_u", 32'h2002, 32'h0, 32'h8001_1234, 2'd1, 1'b0, 1'b0, 1'b1, 0, 1);
    doTxn("backpress", 32'h5004, 32'hCAFE_F00D, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 5, 0);
    doTxn("timeout", 32'h6000, 32'h0, 32'h1111_2222, 2'd2, 1'b0, 1'b0, 1'b1, 0, 0);
    doTxn("late_drop", 32'h6004, 32'h0, 32'h3333_4444, 2'd2, 1'b0, 1'b0, 1'b1, 1, MT + 3);
    doTxn("edge_win", 32'h6008, 32'h0, 32'h5555_6666, 2'd0, 1'b1, 1'b0, 1'b1, 0, MT);
    doTxn("no_op", 32'h7000, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 0, 1);
    doTxn("both_st", 32'h7002, 32'h0000_BEEF, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 0, 1);
    doTxn("sz3_word", 32'h7007, 32'h0, 32'h89AB_CDEF, 2'd3, 1'b1, 1'b0, 1'b1, 2, 2);
`ifdef BIG_CORE_LSU_MISALIGN_CHK_EN
    doTxn("misalign", 32'h4002, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1, 0, 1);
`endif

    // abort a load while it waits for read data
    @(negedge Clk);
    CoreReqValid = 1'b1; CoreAddress = 32'h3000; CoreSize = 2'd2; CoreRdEn = 1'b1; CoreWrEn = 1'b0;
    @(negedge Clk);
    CoreReqValid = 1'b0; MemReqReady = 1'b1;
    @(negedge Clk);
    MemReqReady = 1'b0; Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_ready", 32'(CoreReqReady), 32'd1);
    check("abort_mreqv", 32'(MemReqValid), 32'd0);
    rspSeen = 0;
    for (int i = 0; i < MT + 6; i++) begin
      if (CoreRspValid) rspSeen++;
      @(negedge Clk);
    end
    check("abort_norsp", 32'(rspSeen), 32'd0);
    doTxn("post_rst", 32'h3000, 32'h0, 32'h1234_5678, 2'd2, 1'b0, 1'b0, 1'b1, 0, 1);

    for (int n = 0; n < 40; n++) begin
      rsz  = 2'($urandom_range(0, 3));
      rwr  = 1'($urandom_range(0, 1));
      rrd  = ($urandom_range(0, 7) != 0) ? ~rwr : 1'b0;
      rdel = $urandom_range(1, MT + 2);
      doTxn($sformatf("rnd%0d", n), $urandom, $urandom, $urandom, rsz,
            1'($urandom_range(0, 1)), rwr, rrd, $urandom_range(0, 3), rdel);
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end
endmodule
